// File: rtl/tt_um_priority_decoder.sv
// Priority-index decoder: 2-stage capture/commit pipeline that accumulates
// one-hot codes into a mask, with count, sticky status and byte readout.
module tt_um_priority_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic        s1_valid;
  logic [7:0]  s1_code;
  logic [15:0] mask;
  logic [7:0]  count;
  logic        err;
  logic        none_seen;
  logic [3:0]  last_code;
  logic        commit_q;
  logic        dup_q;

  logic        clr;
  logic        is_idx;
  logic        is_none;
  logic [15:0] onehot;
  logic        take;
  logic        commit;
  logic        bad;
  logic        dup;
  logic        mask_full;
  logic        unused_ok;

  assign clr       = uio_in[1];
  assign unused_ok = &{1'b0, uio_in[7:4]};

  always_comb begin
    is_idx  = (s1_code[7:4] == 4'h0);
    is_none = (s1_code == 8'hF0);
    onehot  = 16'h0001 << s1_code[3:0];
    take    = s1_valid & ~clr;
    commit  = take & (is_idx | is_none);
    bad     = take & ~is_idx & ~is_none;
    dup     = take & is_idx & (|(mask & onehot));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= 8'h00;
    end else begin
      s1_valid <= ena & uio_in[0] & ~clr;
      s1_code  <= ui_in;
    end
  end

  // Clear wins over any commit from stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= 16'h0000;
      count     <= 8'h00;
      err       <= 1'b0;
      none_seen <= 1'b0;
      last_code <= 4'h0;
      commit_q  <= 1'b0;
      dup_q     <= 1'b0;
    end else if (clr) begin
      mask      <= 16'h0000;
      count     <= 8'h00;
      err       <= 1'b0;
      none_seen <= 1'b0;
      last_code <= 4'h0;
      commit_q  <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      commit_q <= commit;
      dup_q    <= dup;
      if (commit && is_idx)
        mask <= mask | onehot;
      if (commit) begin
        if (count != 8'hFF)
          count <= count + 8'h01;
        last_code <= s1_code[3:0];
      end
      if (commit && is_none)
        none_seen <= 1'b1;
      if (bad)
        err <= 1'b1;
    end
  end

  assign mask_full = (mask == 16'hFFFF);

  always_comb begin
    uo_out = 8'h00;
    unique case (uio_in[3:2])
      2'b00: uo_out = mask[7:0];
      2'b01: uo_out = mask[15:8];
      2'b10: uo_out = count;
      2'b11: uo_out = {err, none_seen, mask_full, 1'b0, last_code};
    endcase
  end

  assign uio_out = {dup_q, mask_full, err, commit_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Bench for tt_um_priority_decoder: vector table through a scoreboard
// queue, plus reset, ena and saturation sequences.
module tb_tt_um_priority_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] code;
  logic       vld;
  logic       clr;
  logic [1:0] sel;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uio_in;

  int checks = 0;
  int errors = 0;

  assign uio_in = {4'h0, sel, clr, vld};

  tt_um_priority_decoder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (en),
    .ui_in  (code),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic        vld;
    logic        clr;
    logic        en;
    logic [15:0] mask;
    logic [7:0]  cnt;
    logic [7:0]  stat;
    logic [7:0]  uio;
  } vec_t;

  vec_t vt[$];
  vec_t eq[$];

  task automatic add(input logic [7:0] c, input logic v, input logic cl,
                     input logic e, input logic [15:0] m,
                     input logic [7:0] n, input logic [7:0] s,
                     input logic [7:0] u);
    vec_t x;
    x.code = c; x.vld = v; x.clr = cl; x.en = e;
    x.mask = m; x.cnt = n; x.stat = s; x.uio = u;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, output logic [7:0] v);
    sel = s;
    #1;
    v = uo_out;
  endtask

  task automatic cmp(input vec_t x, input int idx);
    logic [7:0] v;
    rd(2'b00, v); chk("mask_lo", idx, {8'h00, v}, {8'h00, x.mask[7:0]});
    rd(2'b01, v); chk("mask_hi", idx, {8'h00, v}, {8'h00, x.mask[15:8]});
    rd(2'b10, v); chk("count", idx, {8'h00, v}, {8'h00, x.cnt});
    rd(2'b11, v); chk("status", idx, {8'h00, v}, {8'h00, x.stat});
    chk("uio_out", idx, {8'h00, uio_out}, {8'h00, x.uio});
  endtask

  task automatic chk_zero(input int idx);
    logic [7:0] v;
    for (int s = 0; s < 4; s++) begin
      rd(s[1:0], v);
      chk("rst_sel", idx * 4 + s, {8'h00, v}, 16'h0000);
    end
    chk("rst_uio_out", idx, {8'h00, uio_out}, 16'h0000);
    chk("rst_uio_oe", idx, {8'h00, uio_oe}, 16'h00F0);
  endtask

  initial begin
    vec_t x;
    logic [7:0] v;
    logic [31:0] m;

    // Accumulation
    add(8'h00, 1, 0, 1, 16'h0001, 8'd1, 8'h00, 8'h10);
    add(8'h0F, 1, 0, 1, 16'h8001, 8'd2, 8'h0F, 8'h10);
    add(8'h07, 1, 0, 1, 16'h8081, 8'd3, 8'h07, 8'h10);
    add(8'h00, 0, 0, 1, 16'h0000, 8'd0, 8'h00, 8'h00);
    add(8'h00, 0, 1, 1, 16'h0000, 8'd0, 8'h00, 8'h00);
    // Duplicate / none
    add(8'h05, 1, 0, 1, 16'h0020, 8'd1, 8'h05, 8'h10);
    add(8'h05, 1, 0, 1, 16'h0020, 8'd2, 8'h05, 8'h90);
    add(8'hF0, 1, 0, 1, 16'h0020, 8'd3, 8'h40, 8'h10);
    add(8'h00, 0, 0, 1, 16'h0020, 8'd3, 8'h40, 8'h00);
    // Invalid codes, sticky err
    add(8'h10, 1, 0, 1, 16'h0020, 8'd3, 8'hC0, 8'h20);
    add(8'hF1, 1, 0, 1, 16'h0020, 8'd3, 8'hC0, 8'h20);
    add(8'h00, 0, 0, 1, 16'h0020, 8'd3, 8'hC0, 8'h20);
    // Clear collides with 0x02 in stage 1 and same-cycle 0x04
    add(8'h02, 1, 0, 1, 16'h0000, 8'd0, 8'h00, 8'h00);
    add(8'h04, 1, 1, 1, 16'h0000, 8'd0, 8'h00, 8'h00);
    add(8'h00, 0, 0, 1, 16'h0000, 8'd0, 8'h00, 8'h00);
    // All 16 indices
    for (int k = 0; k < 16; k++) begin
      m = (32'h1 << (k + 1)) - 32'h1;
      add(8'(k), 1, 0, 1, m[15:0], 8'(k + 1),
          (k == 15 ? 8'h20 : 8'h00) | 8'(k),
          (k == 15 ? 8'h50 : 8'h10));
    end
    add(8'h00, 0, 0, 1, 16'hFFFF, 8'h10, 8'h2F, 8'h40);
    // ena drops while 0x09 sits in stage 1
    add(8'h09, 1, 0, 1, 16'hFFFF, 8'h11, 8'h29, 8'hD0);
    add(8'h06, 1, 0, 0, 16'hFFFF, 8'h11, 8'h29, 8'h40);
    add(8'h00, 0, 0, 0, 16'hFFFF, 8'h11, 8'h29, 8'h40);

    rst_n = 1'b0; en = 1'b1; code = 8'h00;
    vld = 1'b0; clr = 1'b0; sel = 2'b00;
    #12;
    chk_zero(0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset with a code in flight
    code = 8'h03; vld = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0; vld = 1'b0;
    #1 chk_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    code = 8'h03; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rd(2'b00, v); chk("post_rst_mask_lo", 0, {8'h00, v}, 16'h0008);
    rd(2'b10, v); chk("post_rst_count", 0, {8'h00, v}, 16'h0001);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      code = vt[i].code; vld = vt[i].vld;
      clr = vt[i].clr; en = vt[i].en;
      eq.push_back(vt[i]);
      @(posedge clk);
      @(negedge clk);
      if (eq.size() > 1) begin
        x = eq.pop_front();
        cmp(x, i - 1);
      end
    end
    vld = 1'b0; clr = 1'b0; en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = eq.pop_front();
    cmp(x, vt.size() - 1);

    // Saturation: 260 back-to-back commits
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    code = 8'h01; vld = 1'b1;
    repeat (260) @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    rd(2'b10, v); chk("sat_count", 0, {8'h00, v}, 16'h00FF);
    chk("sat_commit", 0, {15'h0, uio_out[4]}, 16'h0001);
    rd(2'b00, v); chk("sat_mask_lo", 0, {8'h00, v}, 16'h0002);
    @(negedge clk);
    rd(2'b10, v); chk("sat_count_hold", 0, {8'h00, v}, 16'h00FF);
    chk("sat_commit_end", 0, {15'h0, uio_out[4]}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
